// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/flow controller:
// forwarding-mux selects, branch FSM states and the per-cycle control bundle.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SLOT    = 2'd1,
        RESOLVE = 2'd2,
        SQUASH  = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic pc_redirect;
        logic if_load;
        logic bubble_sel;
        logic ex_bubble;
        logic stall;
        logic inc_count;
    } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the stage decoder/datapath and the hazard controller.
// The controller is the slave: it reads stage information and drives controls.
interface pipe_hazard_ctrl_if #(
    parameter int RW = 2
);
    logic          next_is_br;
    logic          br_resolve;
    logic          br_taken;
    logic          stop_dec;
    logic [RW-1:0] src1;
    logic [RW-1:0] src2;
    logic          use1;
    logic          use2;
    logic [RW-1:0] ex_dst;
    logic          ex_wr;
    logic          ex_load;
    logic [RW-1:0] wb_dst;
    logic          wb_wr;

    logic          pc_write;
    logic          pc_redirect;
    logic          if_load;
    logic          bubble_sel;
    logic          ex_bubble;
    logic [1:0]    fwd1;
    logic [1:0]    fwd2;
    logic          stall;
    logic          halted;
    logic          inc_count;

    modport master (
        output next_is_br, br_resolve, br_taken, stop_dec,
               src1, src2, use1, use2, ex_dst, ex_wr, ex_load, wb_dst, wb_wr,
        input  pc_write, pc_redirect, if_load, bubble_sel, ex_bubble,
               fwd1, fwd2, stall, halted, inc_count
    );

    modport slave (
        input  next_is_br, br_resolve, br_taken, stop_dec,
               src1, src2, use1, use2, ex_dst, ex_wr, ex_load, wb_dst, wb_wr,
        output pc_write, pc_redirect, if_load, bubble_sel, ex_bubble,
               fwd1, fwd2, stall, halted, inc_count
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Operand forwarding select for one decode source: EX result beats WB value,
// and a load still in EX cannot forward (its data is not ready yet).
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int RW = 2
) (
    input  logic [RW-1:0] src_i,
    input  logic          use_i,
    input  logic [RW-1:0] ex_dst_i,
    input  logic          ex_wr_i,
    input  logic          ex_load_i,
    input  logic [RW-1:0] wb_dst_i,
    input  logic          wb_wr_i,
    output logic [1:0]    fwd_o,
    output logic          ex_hit_o
);

    assign ex_hit_o = use_i && (src_i == ex_dst_i);

    always_comb begin
        if (ex_hit_o && ex_wr_i && !ex_load_i) begin
            fwd_o = FWD_EX;
        end else if (use_i && wb_wr_i && (src_i == wb_dst_i)) begin
            fwd_o = FWD_WB;
        end else begin
            fwd_o = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flow controller for the 4-stage CPU: forwarding selects, load-use
// interlock, branch bubble (BR_MODE 0) or squash (BR_MODE 1) FSM, sticky halt.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RW          = 2,
    parameter int FLUSH_SLOTS = 2,
    parameter int BR_MODE     = 0
) (
    input  logic             clock,
    input  logic             reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int            CW       = $clog2(FLUSH_SLOTS + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_SLOTS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          halted_q, halted_d;
    ctrl_t         ctrl;

    logic [1:0] fwd1_raw, fwd2_raw;
    logic       hit1, hit2;
    logic       load_use;
    logic       taken;

    fwd_select #(.RW(RW)) u_fwd1 (
        .src_i    (bus.src1),
        .use_i    (bus.use1),
        .ex_dst_i (bus.ex_dst),
        .ex_wr_i  (bus.ex_wr),
        .ex_load_i(bus.ex_load),
        .wb_dst_i (bus.wb_dst),
        .wb_wr_i  (bus.wb_wr),
        .fwd_o    (fwd1_raw),
        .ex_hit_o (hit1)
    );

    fwd_select #(.RW(RW)) u_fwd2 (
        .src_i    (bus.src2),
        .use_i    (bus.use2),
        .ex_dst_i (bus.ex_dst),
        .ex_wr_i  (bus.ex_wr),
        .ex_load_i(bus.ex_load),
        .wb_dst_i (bus.wb_dst),
        .wb_wr_i  (bus.wb_wr),
        .fwd_o    (fwd2_raw),
        .ex_hit_o (hit2)
    );

    assign load_use = (hit1 || hit2) && bus.ex_wr && bus.ex_load;
    assign taken    = bus.br_resolve && bus.br_taken;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        halted_d = halted_q || (bus.stop_dec && !ctrl.bubble_sel);
        if (!halted_q) begin
            unique case (state_q)
                IDLE: begin
                    if (BR_MODE == 0) begin
                        if (bus.next_is_br && !load_use) begin
                            state_d = SLOT;
                            cnt_d   = CNT_INIT;
                        end
                    end else if (taken) begin
                        state_d = SQUASH;
                        cnt_d   = CNT_INIT;
                    end
                end
                SLOT: begin
                    if (cnt_q == '0) state_d = RESOLVE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                RESOLVE: state_d = IDLE;
                SQUASH: begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Reset and halt override everything; the stall branch only runs from IDLE.
    always_comb begin
        ctrl = '0;
        if (!reset && !halted_q) begin
            ctrl.inc_count = 1'b1;
            ctrl.if_load   = 1'b1;
            unique case (state_q)
                IDLE: begin
                    ctrl.pc_write = 1'b1;
                    if (BR_MODE != 0 && taken) begin
                        ctrl.pc_redirect = 1'b1;
                    end else if (load_use) begin
                        ctrl.pc_write  = 1'b0;
                        ctrl.if_load   = 1'b0;
                        ctrl.ex_bubble = 1'b1;
                        ctrl.stall     = 1'b1;
                    end
                end
                SLOT: ctrl.bubble_sel = 1'b1;
                RESOLVE: begin
                    ctrl.bubble_sel  = 1'b1;
                    ctrl.pc_write    = taken;
                    ctrl.pc_redirect = taken;
                end
                SQUASH: begin
                    ctrl.bubble_sel = 1'b1;
                    ctrl.ex_bubble  = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign bus.pc_write    = ctrl.pc_write;
    assign bus.pc_redirect = ctrl.pc_redirect;
    assign bus.if_load     = ctrl.if_load;
    assign bus.bubble_sel  = ctrl.bubble_sel;
    assign bus.ex_bubble   = ctrl.ex_bubble;
    assign bus.stall       = ctrl.stall;
    assign bus.inc_count   = ctrl.inc_count;
    assign bus.halted      = halted_q;
    assign bus.fwd1        = reset ? FWD_RF : fwd1_raw;
    assign bus.fwd2        = reset ? FWD_RF : fwd2_raw;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: dut0 is BR_MODE 0 / FLUSH_SLOTS 2, dut1 is BR_MODE 1 / FLUSH_SLOTS 3.
// Expected outputs are queued as each cycle is driven and popped at the negedge sample.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [1:0] fwd1;
        logic [1:0] fwd2;
        logic       pc_write;
        logic       pc_redirect;
        logic       if_load;
        logic       bubble_sel;
        logic       ex_bubble;
        logic       stall;
        logic       halted;
        logic       inc_count;
    } obs_t;

    typedef struct packed {
        logic       next_is_br;
        logic       br_resolve;
        logic       br_taken;
        logic       stop_dec;
        logic [1:0] src1;
        logic       use1;
        logic [1:0] src2;
        logic       use2;
        logic [1:0] ex_dst;
        logic       ex_wr;
        logic       ex_load;
        logic [1:0] wb_dst;
        logic       wb_wr;
    } stim_t;

    // Bit order: fwd1 fwd2 pc_write pc_redirect if_load bubble_sel ex_bubble stall halted inc_count
    localparam obs_t O_ZERO  = 12'b00_00_0000_0000;
    localparam obs_t O_IDLE  = 12'b00_00_1010_0001;
    localparam obs_t O_SLOT  = 12'b00_00_0011_0001;
    localparam obs_t O_RES_T = 12'b00_00_1111_0001;
    localparam obs_t O_STALL = 12'b00_00_0000_1101;
    localparam obs_t O_REDIR = 12'b00_00_1110_0001;
    localparam obs_t O_SQ    = 12'b00_00_0011_1001;
    localparam obs_t O_HALT  = 12'b00_00_0000_0010;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    obs_t sb[$];

    pipe_hazard_ctrl_if #(.RW(2)) bus0 ();
    pipe_hazard_ctrl_if #(.RW(2)) bus1 ();

    pipe_hazard_ctrl #(.RW(2), .FLUSH_SLOTS(2), .BR_MODE(0)) dut0 (
        .clock(clock),
        .reset(reset),
        .bus  (bus0)
    );

    pipe_hazard_ctrl #(.RW(2), .FLUSH_SLOTS(3), .BR_MODE(1)) dut1 (
        .clock(clock),
        .reset(reset),
        .bus  (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input int d, input stim_t s);
        if (d == 0) begin
            bus0.next_is_br = s.next_is_br; bus0.br_resolve = s.br_resolve;
            bus0.br_taken   = s.br_taken;   bus0.stop_dec   = s.stop_dec;
            bus0.src1 = s.src1; bus0.use1 = s.use1; bus0.src2 = s.src2; bus0.use2 = s.use2;
            bus0.ex_dst = s.ex_dst; bus0.ex_wr = s.ex_wr; bus0.ex_load = s.ex_load;
            bus0.wb_dst = s.wb_dst; bus0.wb_wr = s.wb_wr;
        end else begin
            bus1.next_is_br = s.next_is_br; bus1.br_resolve = s.br_resolve;
            bus1.br_taken   = s.br_taken;   bus1.stop_dec   = s.stop_dec;
            bus1.src1 = s.src1; bus1.use1 = s.use1; bus1.src2 = s.src2; bus1.use2 = s.use2;
            bus1.ex_dst = s.ex_dst; bus1.ex_wr = s.ex_wr; bus1.ex_load = s.ex_load;
            bus1.wb_dst = s.wb_dst; bus1.wb_wr = s.wb_wr;
        end
    endtask

    task automatic idle_all();
        drive(0, '0);
        drive(1, '0);
    endtask

    function automatic obs_t observe(input int d);
        obs_t o;
        if (d == 0) begin
            o = {bus0.fwd1, bus0.fwd2, bus0.pc_write, bus0.pc_redirect, bus0.if_load,
                 bus0.bubble_sel, bus0.ex_bubble, bus0.stall, bus0.halted, bus0.inc_count};
        end else begin
            o = {bus1.fwd1, bus1.fwd2, bus1.pc_write, bus1.pc_redirect, bus1.if_load,
                 bus1.bubble_sel, bus1.ex_bubble, bus1.stall, bus1.halted, bus1.inc_count};
        end
        return o;
    endfunction

    function automatic stim_t lu_stim();
        stim_t s = '0;
        s.ex_load = 1'b1; s.ex_wr = 1'b1; s.ex_dst = 2'd1; s.src2 = 2'd1; s.use2 = 1'b1;
        return s;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        stim_t s = '0;
        obs_t  got, exp;
        s.src1 = 2'd2; s.use1 = 1'b1; s.ex_dst = 2'd2; s.ex_wr = 1'b1; s.next_is_br = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 2) begin
                drive(i % 2, s);
                sb.push_back(O_ZERO);
            end else begin
                if (i == 2) begin
                    idle_all();
                    reset = 1'b0;
                end
                sb.push_back(O_IDLE);
            end
            @(negedge clock);
            got = observe(i % 2);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset[%0d]: got %b expected %b", i, got, exp);
            end
            if (i == 1) next_cycle();
        end
        next_cycle();
    endtask

    task automatic test_forward();
        stim_t s[6];
        obs_t  e[6];
        obs_t  got, exp;
        for (int i = 0; i < 6; i++) begin
            s[i] = '0;
            e[i] = O_IDLE;
        end
        s[0].src1 = 2'd2; s[0].use1 = 1; s[0].ex_dst = 2'd2; s[0].ex_wr = 1; s[0].wb_dst = 2'd2; s[0].wb_wr = 1;
        e[0].fwd1 = 2'b01;
        s[1] = s[0]; s[1].ex_wr = 0; e[1].fwd1 = 2'b10;
        s[2] = s[0]; s[2].use1 = 0;
        s[3].src1 = 2'd1; s[3].use1 = 1; s[3].src2 = 2'd3; s[3].use2 = 1;
        s[3].ex_dst = 2'd1; s[3].ex_wr = 1; s[3].wb_dst = 2'd3; s[3].wb_wr = 1;
        e[3].fwd1 = 2'b01; e[3].fwd2 = 2'b10;
        s[4].use1 = 1; s[4].use2 = 1; s[4].ex_dst = 2'd3; s[4].ex_wr = 1; s[4].wb_dst = 2'd2; s[4].wb_wr = 1;
        s[5].src2 = 2'd2; s[5].use2 = 1; s[5].ex_dst = 2'd2; s[5].ex_wr = 1; s[5].wb_dst = 2'd2;
        e[5].fwd2 = 2'b01;
        for (int i = 0; i < 6; i++) begin
            drive(0, s[i]);
            sb.push_back(e[i]);
            @(negedge clock);
            got = observe(0);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL forward[%0d]: got %b expected %b", i, got, exp);
            end
            next_cycle();
        end
        idle_all();
    endtask

    task automatic test_load_use();
        stim_t s[5];
        obs_t  e[5];
        obs_t  got, exp;
        s[0] = lu_stim(); s[0].next_is_br = 1; e[0] = O_STALL;
        s[1] = '0; s[1].src2 = 2'd1; s[1].use2 = 1; s[1].wb_dst = 2'd1; s[1].wb_wr = 1;
        e[1] = O_IDLE; e[1].fwd2 = 2'b10;
        s[2] = lu_stim(); s[2].ex_wr = 0; e[2] = O_IDLE;
        s[3] = '0; s[3].src1 = 2'd3; s[3].use1 = 1; s[3].ex_dst = 2'd3; s[3].ex_wr = 1;
        s[3].ex_load = 1; s[3].wb_dst = 2'd3; s[3].wb_wr = 1;
        e[3] = O_STALL; e[3].fwd1 = 2'b10;
        s[4] = '0; e[4] = O_IDLE;
        for (int i = 0; i < 5; i++) begin
            drive(0, s[i]);
            sb.push_back(e[i]);
            @(negedge clock);
            got = observe(0);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, got, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch_bubble(input logic resolve, input logic tkn, input obs_t res_exp);
        stim_t s[5];
        obs_t  e[5];
        obs_t  got, exp;
        s[0] = '0; s[0].next_is_br = 1;             e[0] = O_IDLE;
        s[1] = lu_stim(); s[1].next_is_br = 1;      e[1] = O_SLOT;
        s[2] = '0;                                  e[2] = O_SLOT;
        s[3] = '0; s[3].br_resolve = resolve; s[3].br_taken = tkn; e[3] = res_exp;
        s[4] = '0;                                  e[4] = O_IDLE;
        for (int i = 0; i < 5; i++) begin
            drive(0, s[i]);
            sb.push_back(e[i]);
            @(negedge clock);
            got = observe(0);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL branch_bubble(r=%0b,t=%0b)[%0d]: got %b expected %b",
                         resolve, tkn, i, got, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch_squash();
        stim_t s[14];
        obs_t  e[14];
        obs_t  got, exp;
        for (int i = 0; i < 14; i++) s[i] = '0;
        s[0].br_resolve = 1; s[0].br_taken = 1;              e[0] = O_REDIR;
        s[1] = lu_stim(); s[1].next_is_br = 1;
        s[1].br_resolve = 1; s[1].br_taken = 1;              e[1] = O_SQ;
        e[2] = O_SQ;
        e[3] = O_SQ;
        e[4] = O_IDLE;
        s[5].br_resolve = 1; s[5].next_is_br = 1;            e[5] = O_IDLE;
        e[6] = O_IDLE;
        s[7] = lu_stim();                                    e[7] = O_STALL;
        s[8] = lu_stim(); s[8].br_resolve = 1; s[8].br_taken = 1; e[8] = O_REDIR;
        e[9] = O_SQ; e[10] = O_SQ; e[11] = O_SQ;
        e[12] = O_IDLE; e[13] = O_IDLE;
        for (int i = 0; i < 14; i++) begin
            drive(1, s[i]);
            sb.push_back(e[i]);
            @(negedge clock);
            got = observe(1);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL branch_squash[%0d]: got %b expected %b", i, got, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_stop();
        stim_t s;
        obs_t  got, exp;
        for (int i = 0; i < 28; i++) begin
            s = '0;
            if (i == 0) begin
                s.stop_dec = 1; exp = O_IDLE;
            end else if (i <= 20) begin
                if (i % 3 == 0) s = lu_stim();
                s.next_is_br = i[0];
                exp = O_HALT;
            end else if (i == 21) begin
                reset = 1'b1; exp = O_ZERO;
            end else if (i == 22) begin
                reset = 1'b0; exp = O_IDLE;
            end else if (i == 23) begin
                s.next_is_br = 1; exp = O_IDLE;
            end else if (i == 24) begin
                s.stop_dec = 1; exp = O_SLOT;
            end else if (i == 25) begin
                exp = O_SLOT;
            end else if (i == 26) begin
                exp = O_SLOT;
            end else begin
                exp = O_IDLE;
            end
            drive(0, s);
            sb.push_back(exp);
            @(negedge clock);
            got = observe(0);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stop[%0d]: got %b expected %b", i, got, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_slot();
        stim_t s;
        obs_t  got, exp;
        for (int i = 0; i < 5; i++) begin
            s = '0;
            case (i)
                0: begin s.next_is_br = 1; drive(0, s); sb.push_back(O_IDLE); @(negedge clock); end
                1: begin drive(0, s); sb.push_back(O_SLOT); @(negedge clock); end
                2: begin #2; reset = 1'b1; sb.push_back(O_ZERO); #1; end
                3: begin
                    s.br_resolve = 1; s.br_taken = 1; drive(0, s);
                    reset = 1'b0; sb.push_back(O_IDLE); @(negedge clock);
                end
                default: begin drive(0, s); sb.push_back(O_IDLE); @(negedge clock); end
            endcase
            got = observe(0);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid_slot[%0d]: got %b expected %b", i, got, exp);
            end
            if (i != 1) next_cycle();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_all();
        next_cycle();
        test_reset();
        test_forward();
        test_load_use();
        test_branch_bubble(1'b1, 1'b1, O_RES_T);
        test_branch_bubble(1'b1, 1'b0, O_SLOT);
        test_branch_bubble(1'b0, 1'b1, O_SLOT);
        test_branch_squash();
        test_stop();
        test_reset_mid_slot();
        idle_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
